// File: rtl/rtype_seq_pkg.sv
// Shared definitions for the rtype_seq instruction sequencer:
// FSM state encoding, opcode constants, ALU operation codes, bus-mux codes.
package rtype_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_A,
        RD_B,
        WB,
        FIN
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_MOV  = 4'd6;
    localparam logic [3:0] OP_ADDI = 4'd7;
    localparam logic [3:0] OP_CMP  = 4'd8;

    // ALU operation codes; ALU_NONE is what the ALU sees outside RD_B
    localparam logic [3:0] ALU_NONE = 4'd0;
    localparam logic [3:0] ALU_ADD  = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_AND  = 4'd3;
    localparam logic [3:0] ALU_OR   = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_PASS = 4'd6;

    // Bus-mux code for "nothing driven onto the bus"
    localparam int SEL_WAIT = 0;

    // ALU operation used in RD_B; CMP subtracts to set flags, ADDI adds the immediate
    function automatic logic [3:0] alu_code(input logic [3:0] opc);
        logic [3:0] op;
        op = ALU_NONE;
        case (opc)
            OP_ADD:  op = ALU_ADD;
            OP_SUB:  op = ALU_SUB;
            OP_AND:  op = ALU_AND;
            OP_OR:   op = ALU_OR;
            OP_XOR:  op = ALU_XOR;
            OP_MOV:  op = ALU_PASS;
            OP_ADDI: op = ALU_ADD;
            OP_CMP:  op = ALU_SUB;
            default: op = ALU_NONE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/rtype_seq_reg_wen_dec.sv
// reg_wen_dec: 4-bit register index to NREGS-wide one-hot write enable, gated by en.
module reg_wen_dec #(
    parameter int NREGS = 16
) (
    input  logic [3:0]       idx,
    input  logic             en,
    output logic [NREGS-1:0] onehot
);

    // one bit set for the addressed register, none when disabled
    always_comb begin
        onehot = '0;
        for (int i = 0; i < NREGS; i++) begin
            onehot[i] = en && (int'(idx) == i);
        end
    end

endmodule

// File: rtl/rtype_seq.sv
// rtype_seq: sequencer for register-register / register-immediate instructions.
// Walks IDLE -> RD_A -> RD_B -> WB/FIN and drives the bus mux, ALU latches and
// register write enables. All outputs decode from registered state and fields;
// only abort reaches the done/write/illegal pulses combinationally so that an
// abort in WB or FIN suppresses them in that same cycle.
// Optional feature: define RTYPE_SEQ_PERF_EN to add the retired_cnt output.
module rtype_seq
    import rtype_seq_pkg::*;
#(
    parameter int NREGS = 16,
    parameter int SELW  = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             instr_valid,
    input  logic [15:0]      instr,
    output logic             instr_ready,
    input  logic             abort,
    output logic [SELW-1:0]  mux_sel,
    output logic             a_load,
    output logic             res_load,
    output logic             flag_load,
    output logic [3:0]       alu_op,
    output logic             imm_en,
    output logic [3:0]       imm_out,
    output logic [NREGS-1:0] reg_wen,
    output logic             done,
    output logic             illegal
`ifdef RTYPE_SEQ_PERF_EN
    ,
    output logic [15:0]      retired_cnt
`endif
);

    state_t     state, state_nxt;
    logic [3:0] opc_q, rd_q, rs_q, imm_q;
    logic       accept;
    logic       wen_en;

    assign instr_ready = (state == IDLE);
    assign accept      = instr_valid && instr_ready;
    assign imm_out     = imm_q;

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // capture the instruction fields on accept
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            opc_q <= '0;
            rd_q  <= '0;
            rs_q  <= '0;
            imm_q <= '0;
        end else if (accept) begin
            opc_q <= instr[15:12];
            rd_q  <= instr[11:8];
            rs_q  <= instr[7:4];
            imm_q <= instr[3:0];
        end
    end

    // next state; abort from any busy state returns to IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (instr_valid) begin
                    case (instr[15:12])
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
                        OP_ADDI, OP_CMP: state_nxt = RD_A;
                        OP_MOV:          state_nxt = RD_B;
                        default:         state_nxt = FIN;  // NOP and illegal codes
                    endcase
                end
            end
            RD_A:    state_nxt = RD_B;
            RD_B:    state_nxt = (opc_q == OP_CMP) ? FIN : WB;
            WB:      state_nxt = IDLE;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort && state != IDLE) state_nxt = IDLE;
    end

    // datapath controls decoded from the current state and captured fields
    always_comb begin
        mux_sel   = SELW'(SEL_WAIT);
        a_load    = 1'b0;
        res_load  = 1'b0;
        flag_load = 1'b0;
        alu_op    = ALU_NONE;
        imm_en    = 1'b0;
        done      = 1'b0;
        illegal   = 1'b0;
        wen_en    = 1'b0;
        case (state)
            RD_A: begin
                mux_sel = SELW'(rd_q) + SELW'(1);
                a_load  = 1'b1;
            end
            RD_B: begin
                alu_op  = alu_code(opc_q);
                imm_en  = (opc_q == OP_ADDI);
                mux_sel = imm_en ? SELW'(SEL_WAIT) : SELW'(rs_q) + SELW'(1);
                if (opc_q == OP_CMP) flag_load = 1'b1;
                else                 res_load  = 1'b1;
            end
            WB: begin
                wen_en = !abort;
                done   = !abort;
            end
            FIN: begin
                done    = !abort;
                illegal = !abort && (opc_q > OP_CMP);
            end
            default: ;
        endcase
    end

    reg_wen_dec #(
        .NREGS(NREGS)
    ) u_reg_wen_dec (
        .idx   (rd_q),
        .en    (wen_en),
        .onehot(reg_wen)
    );

`ifdef RTYPE_SEQ_PERF_EN
    // count retired legal instructions, wrapping at 16 bits
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                 retired_cnt <= '0;
        else if (done && !illegal) retired_cnt <= retired_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_rtype_seq.sv
// Bench for rtype_seq: a queue-based model expands each accepted instruction
// into its expected per-cycle output steps; every cycle is compared against it.
// Directed sequences add literal expectations; a random phase follows.
module tb_rtype_seq;
    import rtype_seq_pkg::*;

    localparam int NREGS = 16;
    localparam int SELW  = 5;

    logic             clk = 1'b0;
    logic             reset;
    logic             instr_valid;
    logic [15:0]      instr;
    logic             abort;
    logic             instr_ready;
    logic [SELW-1:0]  mux_sel;
    logic             a_load, res_load, flag_load, imm_en, done, illegal;
    logic [3:0]       alu_op, imm_out;
    logic [NREGS-1:0] reg_wen;
`ifdef RTYPE_SEQ_PERF_EN
    logic [15:0]      retired_cnt;
`endif

    rtype_seq #(.NREGS(NREGS), .SELW(SELW)) dut (
        .clk        (clk),
        .reset      (reset),
        .instr_valid(instr_valid),
        .instr      (instr),
        .instr_ready(instr_ready),
        .abort      (abort),
        .mux_sel    (mux_sel),
        .a_load     (a_load),
        .res_load   (res_load),
        .flag_load  (flag_load),
        .alu_op     (alu_op),
        .imm_en     (imm_en),
        .imm_out    (imm_out),
        .reg_wen    (reg_wen),
        .done       (done),
        .illegal    (illegal)
`ifdef RTYPE_SEQ_PERF_EN
        ,
        .retired_cnt(retired_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [SELW-1:0]  mux;
        logic             a, r, f;
        logic [3:0]       alu;
        logic             ie;
        logic [NREGS-1:0] wen;
        logic             dn, ill;
    } step_t;

    step_t      q[$];
    step_t      cur;
    logic [3:0] m_imm;
    int         m_cnt;

    // values sampled in the most recent compare
    logic            s_ready, s_a, s_r, s_f, s_ie, s_done, s_ill;
    logic [SELW-1:0] s_mux;
    logic [3:0]      s_alu, s_imm;
    logic [NREGS-1:0] s_wen;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic step_t mk(input logic [SELW-1:0] mux, input logic a, input logic r,
                                 input logic f, input logic [3:0] alu, input logic ie,
                                 input logic [NREGS-1:0] wen, input logic dn, input logic ill);
        step_t s;
        s.mux = mux; s.a = a; s.r = r; s.f = f; s.alu = alu; s.ie = ie;
        s.wen = wen; s.dn = dn; s.ill = ill;
        return s;
    endfunction

    // expand an accepted instruction into its expected output steps
    function automatic void push_instr(input logic [15:0] ins);
        logic [3:0]       op, rd, rs;
        logic [SELW-1:0]  rdc, rsc;
        logic [NREGS-1:0] one;
        step_t            rda, wb, fin;
        op  = ins[15:12];
        rd  = ins[11:8];
        rs  = ins[7:4];
        rdc = SELW'(rd) + SELW'(1);
        rsc = SELW'(rs) + SELW'(1);
        one = NREGS'(1);
        rda = mk(rdc, 1'b1, 1'b0, 1'b0, ALU_NONE, 1'b0, '0, 1'b0, 1'b0);
        wb  = mk('0, 1'b0, 1'b0, 1'b0, ALU_NONE, 1'b0, one << rd, 1'b1, 1'b0);
        fin = mk('0, 1'b0, 1'b0, 1'b0, ALU_NONE, 1'b0, '0, 1'b1, 1'b0);
        case (op)
            4'd1, 4'd2, 4'd3, 4'd4, 4'd5: begin
                logic [3:0] alu;
                case (op)
                    4'd1:    alu = ALU_ADD;
                    4'd2:    alu = ALU_SUB;
                    4'd3:    alu = ALU_AND;
                    4'd4:    alu = ALU_OR;
                    default: alu = ALU_XOR;
                endcase
                q.push_back(rda);
                q.push_back(mk(rsc, 1'b0, 1'b1, 1'b0, alu, 1'b0, '0, 1'b0, 1'b0));
                q.push_back(wb);
            end
            4'd6: begin
                q.push_back(mk(rsc, 1'b0, 1'b1, 1'b0, ALU_PASS, 1'b0, '0, 1'b0, 1'b0));
                q.push_back(wb);
            end
            4'd7: begin
                q.push_back(rda);
                q.push_back(mk('0, 1'b0, 1'b1, 1'b0, ALU_ADD, 1'b1, '0, 1'b0, 1'b0));
                q.push_back(wb);
            end
            4'd8: begin
                q.push_back(rda);
                q.push_back(mk(rsc, 1'b0, 1'b0, 1'b1, ALU_SUB, 1'b0, '0, 1'b0, 1'b0));
                q.push_back(fin);
            end
            4'd0: q.push_back(fin);
            default: begin
                fin.ill = 1'b1;
                q.push_back(fin);
            end
        endcase
    endfunction

    task automatic compare_cycle();
        bit busy;
        busy = (q.size() != 0);
        if (busy) cur = q[0];
        else      cur = mk('0, 1'b0, 1'b0, 1'b0, ALU_NONE, 1'b0, '0, 1'b0, 1'b0);
        if (busy && abort) begin
            cur.wen = '0;
            cur.dn  = 1'b0;
            cur.ill = 1'b0;
        end
        s_ready = instr_ready; s_mux = mux_sel; s_a = a_load; s_r = res_load;
        s_f = flag_load; s_alu = alu_op; s_ie = imm_en; s_imm = imm_out;
        s_wen = reg_wen; s_done = done; s_ill = illegal;
        chk("instr_ready", 32'(instr_ready), 32'(!busy));
        chk("mux_sel",     32'(mux_sel),     32'(cur.mux));
        chk("a_load",      32'(a_load),      32'(cur.a));
        chk("res_load",    32'(res_load),    32'(cur.r));
        chk("flag_load",   32'(flag_load),   32'(cur.f));
        chk("alu_op",      32'(alu_op),      32'(cur.alu));
        chk("imm_en",      32'(imm_en),      32'(cur.ie));
        chk("imm_out",     32'(imm_out),     32'(m_imm));
        chk("reg_wen",     32'(reg_wen),     32'(cur.wen));
        chk("done",        32'(done),        32'(cur.dn));
        chk("illegal",     32'(illegal),     32'(cur.ill));
`ifdef RTYPE_SEQ_PERF_EN
        chk("retired_cnt", 32'(retired_cnt), 32'(m_cnt[15:0]));
`endif
    endtask

    task automatic update_model();
        if (q.size() != 0) begin
            if (cur.dn && !cur.ill) m_cnt++;
            if (abort) q.delete();
            else       void'(q.pop_front());
        end else if (instr_valid) begin
            push_instr(instr);
            m_imm = instr[3:0];
        end
    endtask

    // one clock cycle: drive, compare at negedge, advance model at posedge
    task automatic cyc(input logic v, input logic [15:0] ins, input logic ab);
        instr_valid = v;
        instr       = ins;
        abort       = ab;
        @(negedge clk);
        compare_cycle();
        @(posedge clk);
        update_model();
        #1;
    endtask

    task automatic model_reset();
        q.delete();
        m_imm = '0;
        m_cnt = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, first_i, second_i;
        reset = 1'b1; instr_valid = 1'b0; instr = '0; abort = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready",   32'(instr_ready), 32'd1);
        chk("rst_mux",     32'(mux_sel),     32'd0);
        chk("rst_reg_wen", 32'(reg_wen),     32'd0);
        chk("rst_done",    32'(done),        32'd0);
        chk("rst_imm_out", 32'(imm_out),     32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // ADD r3,r5
        cyc(1'b1, 16'h1350, 1'b0);
        chk("add_accept", 32'(s_ready), 32'd1);
        cyc(1'b0, 16'h0000, 1'b0);
        chk("add_c1_mux", 32'(s_mux), 32'd4);
        chk("add_c1_aload", 32'(s_a), 32'd1);
        cyc(1'b0, 16'h0000, 1'b0);
        chk("add_c2_mux", 32'(s_mux), 32'd6);
        chk("add_c2_resload", 32'(s_r), 32'd1);
        cyc(1'b0, 16'h0000, 1'b0);
        chk("add_c3_wen", 32'(s_wen), 32'h0008);
        chk("add_c3_done", 32'(s_done), 32'd1);

        // ADDI r15,9
        cyc(1'b1, 16'h7F09, 1'b0);
        cyc(1'b0, 16'h0000, 1'b0);
        chk("addi_mux", 32'(s_mux), 32'd16);
        cyc(1'b0, 16'h0000, 1'b0);
        chk("addi_imm_en", 32'(s_ie), 32'd1);
        chk("addi_imm_out", 32'(s_imm), 32'd9);
        cyc(1'b0, 16'h0000, 1'b0);
        chk("addi_wen", 32'(s_wen), 32'h8000);

        // CMP r0,r1
        cyc(1'b1, 16'h8010, 1'b0);
        chk("cmp_wen_acc", 32'(s_wen), 32'd0);
        cyc(1'b0, 16'h0000, 1'b0);
        chk("cmp_wen_rda", 32'(s_wen), 32'd0);
        cyc(1'b0, 16'h0000, 1'b0);
        chk("cmp_flag_load", 32'(s_f), 32'd1);
        chk("cmp_res_load", 32'(s_r), 32'd0);
        cyc(1'b0, 16'h0000, 1'b0);
        chk("cmp_done", 32'(s_done), 32'd1);
        chk("cmp_wen_fin", 32'(s_wen), 32'd0);

        // illegal opcode 0xC
        cyc(1'b1, 16'hC123, 1'b0);
        cyc(1'b0, 16'h0000, 1'b0);
        chk("ill_illegal", 32'(s_ill), 32'd1);
        chk("ill_done", 32'(s_done), 32'd1);
        chk("ill_loads", 32'({s_a, s_r, s_f}), 32'd0);
        chk("ill_wen", 32'(s_wen), 32'd0);

        // ADD r2,r2 with abort in WB, then immediate re-accept
        cyc(1'b1, 16'h1220, 1'b0);
        cyc(1'b0, 16'h0000, 1'b0);
        chk("rr_rda_mux", 32'(s_mux), 32'd3);
        cyc(1'b0, 16'h0000, 1'b0);
        chk("rr_rdb_mux", 32'(s_mux), 32'd3);
        cyc(1'b0, 16'h0000, 1'b1);
        chk("abort_wb_wen", 32'(s_wen), 32'd0);
        chk("abort_wb_done", 32'(s_done), 32'd0);
        cyc(1'b1, 16'h2450, 1'b0);
        chk("abort_reaccept", 32'(s_ready), 32'd1);
        repeat (3) cyc(1'b0, 16'h0000, 1'b0);

        // back-to-back ALU ops with instr_valid held high
        acc = 0; first_i = -1; second_i = -1;
        for (int i = 0; i < 12; i++) begin
            cyc(1'b1, {4'd3, 4'(i), 4'd1, 4'd0}, 1'b0);
            if (s_ready) begin
                acc++;
                if (first_i < 0) first_i = i;
                else if (second_i < 0) second_i = i;
            end
        end
        chk("b2b_accepts", 32'(acc), 32'd3);
        chk("b2b_spacing", 32'(second_i - first_i), 32'd4);

        // reset asserted while in RD_B
        cyc(1'b1, 16'h1350, 1'b0);
        cyc(1'b0, 16'h0000, 1'b0);
        instr_valid = 1'b0;
        #2;
        chk("pre_rst_resload", 32'(res_load), 32'd1);
        reset = 1'b1;
        #1;
        chk("arst_mux", 32'(mux_sel), 32'd0);
        chk("arst_resload", 32'(res_load), 32'd0);
        chk("arst_alu_op", 32'(alu_op), 32'd0);
        chk("arst_ready", 32'(instr_ready), 32'd1);
        chk("arst_imm_out", 32'(imm_out), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("arst_wen", 32'(reg_wen), 32'd0);
        reset = 1'b0;
        model_reset();
        @(posedge clk); #1;
        repeat (3) cyc(1'b0, 16'h0000, 1'b0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [15:0] r;
            r = 16'($urandom);
            cyc(($urandom_range(0, 3) != 0), r, ($urandom_range(0, 11) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
